// File: rtl/tail_light_pwm_dimmer_pkg.sv
// Shared constants and helpers for the tail-light PWM dimmer.
// Latency: none (compile-time constants only).
// Backpressure: none.
package tail_light_pkg;

  // Default channel count and PWM resolution.
  localparam int NUM_CH_DEFAULT       = 6;
  localparam int PWM_BITS_DEFAULT     = 4;
  localparam int RAMP_PERIODS_DEFAULT = 2;

  // Lamp positions in the default 6-channel bit order.
  localparam int CH_LC = 5;
  localparam int CH_LB = 4;
  localparam int CH_LA = 3;
  localparam int CH_RA = 2;
  localparam int CH_RB = 1;
  localparam int CH_RC = 0;

  // Full-scale brightness (and PWM period in cycles) for a given counter width.
  function automatic int pwm_max(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/tail_light_pwm_dimmer_if.sv
// Lamp control bundle: running-light controls in, PWM lamp drive and period strobe out.
// Latency: wires only.
// Backpressure: none; the dimmer always accepts its inputs.
interface tail_light_pwm_dimmer_if
  import tail_light_pkg::*;
#(
  parameter int NUM_CH   = NUM_CH_DEFAULT,
  parameter int PWM_BITS = PWM_BITS_DEFAULT
) ();

  logic                lights;
  logic [NUM_CH-1:0]   on_req;
  logic [PWM_BITS-1:0] dim_level;
  logic [NUM_CH-1:0]   lamp_out;
  logic                pwm_wrap;

  // The sequencer/controller side.
  modport master (
    output lights,
    output on_req,
    output dim_level,
    input  lamp_out,
    input  pwm_wrap
  );

  // The dimmer side.
  modport slave (
    input  lights,
    input  on_req,
    input  dim_level,
    output lamp_out,
    output pwm_wrap
  );

endinterface

// File: rtl/tail_light_pwm_dimmer_channel.sv
// One lamp channel: target select, level register (optionally ramped), PWM comparator.
// Latency: level changes on the update strobe; lamp reflects it one cycle later.
// Backpressure: none. Build option TAIL_LIGHT_FADE_EN makes the level step by one per update.
module tail_light_pwm_channel
  import tail_light_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
  input  logic                dimclk,
  input  logic                reset,
  input  logic                i_upd,
  input  logic                i_on_req,
  input  logic                i_lights,
  input  logic [PWM_BITS-1:0] i_dim_level,
  input  logic [PWM_BITS-1:0] i_cnt,
  output logic                o_lamp
);

  localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(pwm_max(PWM_BITS));

  logic [PWM_BITS-1:0] w_target;
  logic [PWM_BITS-1:0] r_level;
  logic                r_lamp;

  // Brightness wanted right now: a full-on request beats the running light.
  always_comb begin
    w_target = '0;
    if (i_on_req) begin
      w_target = MAX;
    end else if (i_lights) begin
      w_target = i_dim_level;
    end
  end

  // Level only moves on the update strobe so every PWM period is uniform.
  always_ff @(posedge dimclk) begin
    if (reset) begin
      r_level <= '0;
    end else if (i_upd) begin
`ifdef TAIL_LIGHT_FADE_EN
      if (r_level < w_target) begin
        r_level <= r_level + PWM_BITS'(1);
      end else if (r_level > w_target) begin
        r_level <= r_level - PWM_BITS'(1);
      end
`else
      r_level <= w_target;
`endif
    end
  end

  // Counter tops out at MAX-1, so level MAX is solid on and level 0 solid off.
  always_ff @(posedge dimclk) begin
    if (reset) begin
      r_lamp <= 1'b0;
    end else begin
      r_lamp <= (i_cnt < r_level);
    end
  end

  assign o_lamp = r_lamp;

endmodule

// File: rtl/tail_light_pwm_dimmer.sv
// NUM_CH-lamp PWM tail-light dimmer; optional level fade with build macro TAIL_LIGHT_FADE_EN.
// Latency: inputs sampled at the period wrap; lamp follows one cycle after pwm_wrap (worst MAX+1).
// Backpressure: none; inputs are free-running levels, not transactions.
module tail_light_pwm_dimmer
  import tail_light_pkg::*;
#(
  parameter int NUM_CH       = NUM_CH_DEFAULT,
  parameter int PWM_BITS     = PWM_BITS_DEFAULT,
  parameter int RAMP_PERIODS = RAMP_PERIODS_DEFAULT
) (
  input  logic                     dimclk,
  input  logic                     reset,
  tail_light_pwm_dimmer_if.slave   bus
);

  localparam logic [PWM_BITS-1:0] MAX      = PWM_BITS'(pwm_max(PWM_BITS));
  localparam logic [PWM_BITS-1:0] CNT_LAST = MAX - PWM_BITS'(1);

  // A ramp of zero periods would never update the levels.
  if (RAMP_PERIODS < 1) begin : g_bad_ramp
    $error("RAMP_PERIODS must be at least 1");
  end

  logic [PWM_BITS-1:0] r_cnt;
  logic                r_pwm_wrap;
  logic                w_wrap_evt;
  logic                w_upd;
  logic [NUM_CH-1:0]   w_lamp;

  assign w_wrap_evt = (r_cnt == CNT_LAST);

  // Period counter 0..MAX-1 plus the wrap strobe that marks cnt==0.
  always_ff @(posedge dimclk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_pwm_wrap <= 1'b0;
    end else begin
      r_pwm_wrap <= w_wrap_evt;
      r_cnt      <= w_wrap_evt ? '0 : r_cnt + PWM_BITS'(1);
    end
  end

`ifdef TAIL_LIGHT_FADE_EN
  localparam int PS_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(RAMP_PERIODS - 1);

  logic [PS_W-1:0] r_presc;

  // Counts wraps so levels step once every RAMP_PERIODS periods.
  always_ff @(posedge dimclk) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_wrap_evt) begin
      r_presc <= (r_presc == PS_LAST) ? '0 : r_presc + PS_W'(1);
    end
  end

  assign w_upd = w_wrap_evt && (r_presc == PS_LAST);
`else
  assign w_upd = w_wrap_evt;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    tail_light_pwm_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .dimclk      (dimclk),
      .reset       (reset),
      .i_upd       (w_upd),
      .i_on_req    (bus.on_req[gi]),
      .i_lights    (bus.lights),
      .i_dim_level (bus.dim_level),
      .i_cnt       (r_cnt),
      .o_lamp      (w_lamp[gi])
    );
  end

  assign bus.lamp_out = w_lamp;
  assign bus.pwm_wrap = r_pwm_wrap;

endmodule

// File: tb/tb_tail_light_pwm_dimmer.sv
// Bench for tail_light_pwm_dimmer: period-level reference model plus directed duty/latency cases.
// Latency: n/a.
// Backpressure: n/a.
module tb_tail_light_pwm_dimmer;
  import tail_light_pkg::*;

  localparam int NCH  = 6;
  localparam int PB   = 4;
  localparam int RP   = 2;
  localparam int MAXV = 15;

  logic dimclk;
  logic reset;

  int checks = 0;
  int errors = 0;
  int meas [NCH];

  tail_light_pwm_dimmer_if #(.NUM_CH(NCH), .PWM_BITS(PB)) bus ();

  tail_light_pwm_dimmer #(
    .NUM_CH       (NCH),
    .PWM_BITS     (PB),
    .RAMP_PERIODS (RP)
  ) dut (
    .dimclk (dimclk),
    .reset  (reset),
    .bus    (bus)
  );

  initial begin
    dimclk = 1'b0;
    forever #5 dimclk = ~dimclk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not end, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Cycles since reset release, phase within the period, and a level per lamp
  // that is re-evaluated from the inputs only at the end of each period.
  int         m_t;
  int         m_lvl [NCH];
  int         m_presc;
  int         m_phase;
  int         m_tgt;
  bit         m_ok = 1'b0;
  logic [NCH-1:0] exp_lamp;
  logic       exp_wrap;

  always @(posedge dimclk) begin
    if (reset) begin
      m_t      = 0;
      m_presc  = 0;
      for (int i = 0; i < NCH; i++) m_lvl[i] = 0;
      exp_lamp = '0;
      exp_wrap = 1'b0;
      m_ok     = 1'b1;
    end else if (m_ok) begin
      m_phase = m_t % MAXV;
      for (int i = 0; i < NCH; i++) exp_lamp[i] = (m_phase < m_lvl[i]);
      exp_wrap = (m_phase == MAXV - 1);
      if (m_phase == MAXV - 1) begin
`ifdef TAIL_LIGHT_FADE_EN
        if (m_presc == RP - 1) begin
          for (int i = 0; i < NCH; i++) begin
            m_tgt = bus.on_req[i] ? MAXV : (bus.lights ? int'(bus.dim_level) : 0);
            if (m_lvl[i] < m_tgt) m_lvl[i] = m_lvl[i] + 1;
            else if (m_lvl[i] > m_tgt) m_lvl[i] = m_lvl[i] - 1;
          end
          m_presc = 0;
        end else begin
          m_presc = m_presc + 1;
        end
`else
        for (int i = 0; i < NCH; i++)
          m_lvl[i] = bus.on_req[i] ? MAXV : (bus.lights ? int'(bus.dim_level) : 0);
`endif
      end
      m_t = m_t + 1;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge dimclk) begin
    if (m_ok) begin
      checks++;
      if (bus.lamp_out !== exp_lamp) begin
        errors++;
        $display("FAIL lamp_out t=%0t actual=%b required=%b", $time, bus.lamp_out, exp_lamp);
      end
      checks++;
      if (bus.pwm_wrap !== exp_wrap) begin
        errors++;
        $display("FAIL pwm_wrap t=%0t actual=%b required=%b", $time, bus.pwm_wrap, exp_wrap);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge dimclk);
    #2;
  endtask

  task automatic wait_wrap();
    int n;
    n = 0;
    do begin
      @(negedge dimclk);
      n++;
    end while (bus.pwm_wrap !== 1'b1 && n < 40);
    check("wrap_seen", int'(bus.pwm_wrap === 1'b1), 1);
  endtask

  task automatic wait_wraps(input int n);
    repeat (n) wait_wrap();
  endtask

  // Counts high cycles per lamp over the full period that follows the next wrap.
  task automatic measure();
    wait_wrap();
    for (int i = 0; i < NCH; i++) meas[i] = 0;
    repeat (MAXV) begin
      @(negedge dimclk);
      for (int i = 0; i < NCH; i++) meas[i] += int'(bus.lamp_out[i]);
    end
  endtask

  task automatic check_all(input string name, input int exp);
    for (int i = 0; i < NCH; i++) check(name, meas[i], exp);
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset         = 1'b1;
    bus.lights    = 1'b1;
    bus.on_req    = '0;
    bus.dim_level = 4'd5;
`ifdef TAIL_LIGHT_FADE_EN
    bus.dim_level = 4'd3;
    bus.on_req    = NCH'(1) << CH_RC;
`endif
    tick();
    tick();
    @(negedge dimclk);
    check("reset_lamp", int'(bus.lamp_out), 0);
    check("reset_wrap", int'(bus.pwm_wrap), 0);
    tick();
    reset = 1'b0;

`ifdef TAIL_LIGHT_FADE_EN
    // Ramp 0 -> 15 on channel RC, one step every second wrap.
    wait_wraps(28);
    measure();
    check("fade_up_w29", meas[CH_RC], 14);
    check("fade_other", meas[CH_RB], 3);
    measure();
    check("fade_up_w31", meas[CH_RC], 15);

    // Ramp to 8, then drop the request: descend to dim_level 3 and hold.
    do_reset();
    wait_wraps(16);
    tick();
    bus.on_req = '0;
    measure();
    check("fade_dn_8", meas[CH_RC], 8);
    measure();
    check("fade_dn_7", meas[CH_RC], 7);
    wait_wraps(5);
    measure();
    check("fade_dn_3", meas[CH_RC], 3);
    measure();
    check("fade_hold_3", meas[CH_RC], 3);
`else
    // Steady dim level 5: 5 of every 15 cycles, wraps 15 apart.
    measure();
    check_all("duty_5", 5);
    check("wrap_period", int'(bus.pwm_wrap), 1);

    // Full-on request raised mid-period takes over at the next wrap.
    wait_wrap();
    repeat (6) tick();
    bus.on_req = NCH'(1) << CH_RA;
    measure();
    check("onreq_ra", meas[CH_RA], 15);
    check("onreq_lc", meas[CH_LC], 5);
    check("onreq_rc", meas[CH_RC], 5);

    // Lights off, then solid full dim, then zero dim.
    tick();
    bus.on_req = '0;
    bus.lights = 1'b0;
    measure();
    check_all("lights_off", 0);
    tick();
    bus.lights    = 1'b1;
    bus.dim_level = 4'd15;
    measure();
    check_all("dim_15", 15);
    tick();
    bus.dim_level = 4'd0;
    measure();
    check_all("dim_0", 0);

    // Single-step level change 2 -> 12.
    tick();
    bus.dim_level = 4'd2;
    measure();
    check("dim_2", meas[CH_LA], 2);
    tick();
    bus.dim_level = 4'd12;
    measure();
    check("dim_12", meas[CH_LA], 12);
    check("dim_12_rb", meas[CH_RB], 12);
`endif

    // Reset pulse with cnt=7 aborts the period; next wrap 15 cycles later.
    bus.on_req    = '0;
    bus.lights    = 1'b1;
    bus.dim_level = 4'd5;
    wait_wrap();
    repeat (7) @(posedge dimclk);
    #2;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge dimclk);
    check("rst_mid_lamp", int'(bus.lamp_out), 0);
    check("rst_mid_wrap", int'(bus.pwm_wrap), 0);
    n = 0;
    do begin
      @(negedge dimclk);
      n++;
    end while (bus.pwm_wrap !== 1'b1 && n < 40);
    check("rst_wrap_gap", n, 15);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
